// File: rtl/addsub_pkg.sv
// Shared encodings for the digit-serial adder/subtractor: operation codes and FSM states.
// Imported by the top level and the testbench.
package addsub_pkg;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_SUB     = 2'b01;
  localparam logic [1:0] OP_ACC_ADD = 2'b10;
  localparam logic [1:0] OP_ACC_SUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_serial_acc_if.sv
// Operand/result bundle for addsub_serial_acc: valid/ready request side and result/flag side.
// master drives operands and out_ready; slave is the arithmetic block.
interface addsub_serial_acc_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             negative;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, op, a, b, cin, out_ready,
    input  in_ready, out_valid, result, cout, overflow, zero, negative, acc
  );

  modport slave (
    input  in_valid, op, a, b, cin, out_ready,
    output in_ready, out_valid, result, cout, overflow, zero, negative, acc
  );

endinterface

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple slice of 1-bit full adders.
// c_msb is the carry entering the slice's top bit, used for signed overflow.
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  always_comb begin
    logic c;
    s     = '0;
    c     = ci;
    c_msb = ci;
    for (int i = 0; i < DIGIT; i++) begin
      c_msb = c;
      s[i]  = x[i] ^ y[i] ^ c;
      c     = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/addsub_serial_acc.sv
// Digit-serial add/sub with accumulator: WIDTH/DIGIT RUN cycles, LSB slice first.
// Result and flags are registered on the RUN->DONE edge and held until out_ready.
module addsub_serial_acc
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  addsub_serial_acc_if.slave bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("addsub_serial_acc: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             acc_op_q, acc_op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic [DIGIT-1:0] dig_s;
  logic             dig_co;
  logic             dig_cm;

  // X and Y shift right each cycle, so the slice always sees the low digit.
  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .x     (x_q[DIGIT-1:0]),
    .y     (y_q[DIGIT-1:0]),
    .ci    (carry_q),
    .s     (dig_s),
    .co    (dig_co),
    .c_msb (dig_cm)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    acc_op_d = acc_op_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    acc_d    = acc_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d      = bus.op[1] ? acc_q : bus.a;
          y_d      = bus.op[0] ? ~bus.b : bus.b;
          carry_d  = bus.cin ^ bus.op[0];
          sum_d    = '0;
          cnt_d    = '0;
          acc_op_d = bus.op[1];
          state_d  = RUN;
        end
      end
      RUN: begin
        x_d     = x_q >> DIGIT;
        y_d     = y_q >> DIGIT;
        sum_d   = (WIDTH'(dig_s) << (WIDTH - DIGIT)) | (sum_q >> DIGIT);
        carry_d = dig_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = DONE;
          result_d = sum_d;
          cout_d   = dig_co;
          ovf_d    = dig_co ^ dig_cm;
          zero_d   = (sum_d == '0);
          neg_d    = sum_d[WIDTH-1];
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          if (acc_op_q) acc_d = result_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      acc_op_q <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      acc_op_q <= acc_op_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = neg_q;
  assign bus.acc       = acc_q;

endmodule
